// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and request record for the write-back arbiter
package rf_wb_arbiter_pkg;

    localparam int N_REQ_DFLT = 4;
    localparam int AW         = 5;
    localparam int DW         = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_pick2.sv
// rtl/rf_wb_arbiter_pick2.sv - combinational two-port picker (module wb_pick2), rotating scan from ptr
module wb_pick2
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N  = N_REQ_DFLT,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]    elig_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [N-1:0]    gnt1_o,
    output logic [N-1:0]    gnt2_o,
    output logic            vld1_o,
    output logic            vld2_o
);

    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic [AW-1:0] cur;
    logic [AW-1:0] addr1;

    always_comb begin
        gnt1_o = '0;
        gnt2_o = '0;
        vld1_o = 1'b0;
        vld2_o = 1'b0;
        addr1  = '0;
        sum    = '0;
        idx    = '0;
        cur    = '0;
        for (int k = 0; k < N; k++) begin
            // wrap ptr+k without a modulo so non-power-of-two N works
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            cur = addr_i[idx*AW +: AW];
            if (elig_i[idx]) begin
                if (!vld1_o) begin
                    vld1_o      = 1'b1;
                    gnt1_o[idx] = 1'b1;
                    addr1       = cur;
                end else if (!vld2_o && (cur != addr1)) begin
                    vld2_o      = 1'b1;
                    gnt2_o[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back arbiter; RF_WB_ROTATE_EN enables rotating priority
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                we1,
    output logic [AW-1:0]       waddr1,
    output logic [DW-1:0]       wdata1,
    output logic                we2,
    output logic [AW-1:0]       waddr2,
    output logic [DW-1:0]       wdata2
);

    localparam int PW = $clog2(N_REQ);

    wb_req_t          req [N_REQ];
    logic [N_REQ-1:0] nz;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt1, gnt2;
    logic             vld1, vld2;
    logic [PW-1:0]    ptr;
    wb_req_t          sel1, sel2;

    logic          we1_q, we2_q;
    logic [AW-1:0] waddr1_q, waddr2_q;
    logic [DW-1:0] wdata1_q, wdata2_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i].addr = req_addr[i*AW +: AW];
            req[i].data = req_data[i*DW +: DW];
            nz[i]       = (req_addr[i*AW +: AW] != '0);
        end
    end

    // r0 writes are acknowledged and discarded; they never reach the picker
    assign elig      = req_valid & nz;
    assign req_ready = (req_valid & ~nz) | gnt1 | gnt2;

    wb_pick2 #(.N(N_REQ), .PW(PW)) u_pick (
        .elig_i (elig),
        .addr_i (req_addr),
        .ptr_i  (ptr),
        .gnt1_o (gnt1),
        .gnt2_o (gnt2),
        .vld1_o (vld1),
        .vld2_o (vld2)
    );

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt1[i]) sel1 = req[i];
            if (gnt2[i]) sel2 = req[i];
        end
    end

`ifdef RF_WB_ROTATE_EN
    logic [PW-1:0] ptr_q, ptr_d, last;

    always_comb begin
        last = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vld2 ? gnt2[i] : gnt1[i]) last = PW'(i);
        end
        ptr_d = ptr_q;
        if (vld1) begin
            ptr_d = (last == PW'(N_REQ-1)) ? '0 : last + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else begin
            we1_q <= vld1;
            we2_q <= vld2;
            if (vld1) begin
                waddr1_q <= sel1.addr;
                wdata1_q <= sel1.data;
            end
            if (vld2) begin
                waddr2_q <= sel2.addr;
                wdata2_q <= sel2.data;
            end
        end
    end

    assign we1    = we1_q;
    assign we2    = we2_q;
    assign waddr1 = waddr1_q;
    assign waddr2 = waddr2_q;
    assign wdata1 = wdata1_q;
    assign wdata2 = wdata2_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter (both RF_WB_ROTATE_EN settings)
module tb_rf_wb_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          we1, we2;
    logic [4:0]    waddr1, waddr2;
    logic [31:0]   wdata1, wdata2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  v;
        logic [19:0] a;
        logic [3:0]  rdy;
        logic        we1;
        logic [4:0]  wa1;
        int          s1;
        logic        we2;
        logic [4:0]  wa2;
        int          s2;
    } vec_t;

    vec_t vecs [10];
    int   cnt  [N];

    rf_wb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .we2       (we2),
        .waddr2    (waddr2),
        .wdata2    (wdata2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dval(input int i, input logic [4:0] a);
        return {8'hA0 + 8'(i), 19'h0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        #3;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] v, input logic [19:0] a);
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = v[i];
            req_addr[i*5 +: 5]  = a[i*5 +: 5];
            req_data[i*32 +: 32] = dval(i, a[i*5 +: 5]);
        end
    endtask

    task automatic check_out(input string tag, input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                             input logic e2, input logic [4:0] a2, input logic [31:0] d2);
        chk({tag, ".we1"},    64'(we1),    64'(e1));
        chk({tag, ".waddr1"}, 64'(waddr1), 64'(a1));
        chk({tag, ".wdata1"}, 64'(wdata1), 64'(d1));
        chk({tag, ".we2"},    64'(we2),    64'(e2));
        chk({tag, ".waddr2"}, 64'(waddr2), 64'(a2));
        chk({tag, ".wdata2"}, 64'(wdata2), 64'(d2));
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        reset     = 1'b1;

        //            valid    {a3,a2,a1,a0}                 ready    we1 wa1  s1 we2 wa2  s2
        vecs[0] = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0011, 1, 5'd1,  0, 1, 5'd2, 1};
        vecs[1] = '{4'b0011, {5'd0, 5'd0, 5'd7, 5'd7},   4'b0001, 1, 5'd7,  0, 0, 5'd0, 0};
        vecs[2] = '{4'b0011, {5'd0, 5'd0, 5'd9, 5'd0},   4'b0011, 1, 5'd9,  1, 0, 5'd0, 0};
        vecs[3] = '{4'b0000, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0000, 0, 5'd0,  0, 0, 5'd0, 0};
        vecs[4] = '{4'b1100, {5'd6, 5'd5, 5'd0, 5'd0},   4'b1100, 1, 5'd5,  2, 1, 5'd6, 3};
        vecs[5] = '{4'b1111, {5'd0, 5'd0, 5'd0, 5'd0},   4'b1111, 0, 5'd0,  0, 0, 5'd0, 0};
        vecs[6] = '{4'b1011, {5'd3, 5'd0, 5'd3, 5'd3},   4'b0001, 1, 5'd3,  0, 0, 5'd0, 0};
        vecs[7] = '{4'b1011, {5'd8, 5'd0, 5'd3, 5'd3},   4'b1001, 1, 5'd3,  0, 1, 5'd8, 3};
        vecs[8] = '{4'b0110, {5'd0, 5'd4, 5'd0, 5'd0},   4'b0110, 1, 5'd4,  2, 0, 5'd0, 0};
        vecs[9] = '{4'b1000, {5'd31, 5'd0, 5'd0, 5'd0},  4'b1000, 1, 5'd31, 3, 0, 5'd0, 0};

        do_reset();
        check_out("reset", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // single-cycle vectors, each from a fresh reset (ptr=0)
        for (int k = 0; k < 10; k++) begin
            do_reset();
            load(vecs[k].v, vecs[k].a);
            #1;
            chk($sformatf("vec%0d.ready", k), 64'(req_ready), 64'(vecs[k].rdy));
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", k),
                      vecs[k].we1, vecs[k].wa1, vecs[k].we1 ? dval(vecs[k].s1, vecs[k].wa1) : 32'd0,
                      vecs[k].we2, vecs[k].wa2, vecs[k].we2 ? dval(vecs[k].s2, vecs[k].wa2) : 32'd0);
            req_valid = '0;
        end

        // asynchronous reset while a write is on the port
        do_reset();
        load(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5});
        @(posedge clk);
        #1;
        chk("midrst.pre_we1", 64'(we1), 64'd1);
        #2;
        reset     = 1'b1;
        req_valid = '0;
        #1;
        check_out("midrst.async", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b0100;
        req_addr  = '0;
        req_addr[14:10]  = 5'd5;
        req_data[95:64]  = 32'hAA;
        @(posedge clk);
        #1;
        check_out("midrst.post", 1, 5'd5, 32'hAA, 0, 5'd0, 32'd0);
        req_valid = '0;

        // two back-to-back cycles of paired grants
        do_reset();
        load(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        #1;
        chk("pair.c0.ready", 64'(req_ready), 64'(4'b0011));
        @(posedge clk);
        #1;
        check_out("pair.c0", 1, 5'd1, dval(0, 5'd1), 1, 5'd2, dval(1, 5'd2));
        load(4'b1100, {5'd4, 5'd3, 5'd2, 5'd1});
        #1;
        chk("pair.c1.ready", 64'(req_ready), 64'(4'b1100));
        @(posedge clk);
        #1;
        check_out("pair.c1", 1, 5'd3, dval(2, 5'd3), 1, 5'd4, dval(3, 5'd4));
        req_valid = '0;

        // same-address deferral, retry, then idle hold of port values
        do_reset();
        load(4'b0011, {5'd0, 5'd0, 5'd7, 5'd7});
        #1;
        chk("same.c0.ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        #1;
        chk("same.c1.ready", 64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        check_out("same.c1", 1, 5'd7, dval(1, 5'd7), 0, 5'd0, 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        check_out("same.idle", 0, 5'd7, dval(1, 5'd7), 0, 5'd0, 32'd0);

        // r0 drop followed by a full request set: priority after the drop
        do_reset();
        load(4'b0011, {5'd0, 5'd0, 5'd9, 5'd0});
        @(posedge clk);
        #1;
        load(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        #1;
`ifdef RF_WB_ROTATE_EN
        chk("r0ptr.ready", 64'(req_ready), 64'(4'b1100));
`else
        chk("r0ptr.ready", 64'(req_ready), 64'(4'b0011));
`endif
        req_valid = '0;

        // sustained load: four continuously valid distinct-address requesters
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        load(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
        end
        for (int i = 0; i < N; i++) begin
`ifdef RF_WB_ROTATE_EN
            chk($sformatf("fair.cnt%0d", i), 64'(cnt[i]), 64'd50);
`else
            chk($sformatf("fixed.cnt%0d", i), 64'(cnt[i]), (i < 2) ? 64'd100 : 64'd0);
`endif
        end
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that shares the register file's two write ports among N_REQ result producers (both issue pipes, multiply/divide unit, load unit). Each cycle it accepts up to two requests over valid/ready handshakes, using rotating priority. It drops writes to r0 without consuming a port, and never issues two writes to the same register in one cycle. Accepted writes drive the register file write ports (we1/waddr1/wdata1, we2/waddr2/wdata2) from output registers, one cycle after acceptance.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  request i holds a write.
- req_addr  input  N_REQ×5  destination register per requester.
- req_data  input  N_REQ×32  write data per requester.
- req_ready  output  N_REQ  request i is accepted this cycle (combinational).
- we1, we2  output  1  register file write enables (registered).
- waddr1, waddr2  output  5  register file write addresses (registered).
- wdata1, wdata2  output  32  register file write data (registered).

## Operation
- Acceptance: request i is accepted in a cycle iff req_valid[i] && req_ready[i]. Requester holds valid/addr/data stable until accepted; req_valid must not depend on req_ready.
- r0 requests (valid, addr==0): req_ready=1 unconditionally. They use no port and do not affect the pointer.
- Scan order: ptr, ptr+1, …, ptr+N_REQ-1 (mod N_REQ), over valid nonzero-address requests.
  - First in scan order takes port 1.
  - Next in scan order whose addr differs from port 1's addr takes port 2.
  - Same-address or further requests get req_ready=0 and retry next cycle.
- Pointer update: if any nonzero request is granted, ptr <= (scan-last granted index + 1) mod N_REQ; otherwise ptr is unchanged.
- Output registers load every cycle:
  - we1 <= port1 granted; waddr1/wdata1 <= granted request's addr/data, or hold previous value when not granted.
  - Port 2 follows the same rule.
- With only one grant, it is always on port 1; we2=0.
- No state machine beyond ptr (log2 N_REQ bits) and the output registers.

## Timing
- Reset (async assert): we1=we2=0, waddr1=waddr2=0, wdata1=wdata2=0, ptr=0. Writes accepted in the cycle before reset asserts are lost.
- Latency: accepted in cycle t → we asserted in cycle t+1 → register file updated at the end of cycle t+1.
- Throughput: 2 writes/cycle sustained when addresses differ.
- req_ready is combinational from req_valid, req_addr and ptr only.
- Starvation bound: a continuously valid request is granted within ceil(N_REQ/2) cycles, or N_REQ cycles under repeated same-address conflicts.

## Configuration
- RF_WB_ROTATE_EN defined: rotating priority as above.
- RF_WB_ROTATE_EN undefined:
  - ptr is removed and fixed at 0, so requester 0 always has highest priority.
  - All other rules (r0 drop, same-address deferral, port ordering, latency) are unchanged.
  - No starvation bound applies.

## Structure
- Shared package: N_REQ default constant, and the typedef wb_req_t {addr[4:0], data[31:0]}.
- One sub-module: wb_pick2.
  - Purely combinational.
  - Takes an eligible mask, an address array and ptr.
  - Returns two one-hot grants plus valid bits, applying the same-address exclusion.
  - The top level holds ptr, the output registers and the r0 filtering.

## Test plan
- Reset mid-stream: assert reset while we1=1 → all outputs 0 immediately (async). After release, req 2 valid addr=5 data=0xAA → next cycle we1=1, waddr1=5, wdata1=0xAA, we2=0.
- Four valid requests, addrs 1/2/3/4, ptr=0:
  - Cycle 0 grants req 0 (port 1) and req 1 (port 2); ptr becomes 2.
  - Cycle 1 grants req 2 and req 3.
  - Outputs show (1,2), then (3,4).
- Same address: req 0 and req 1 both addr=7 → only req 0 ready; next cycle req 1 granted on port 1.
- r0: req 0 addr=0, req 1 addr=9 → both ready in the same cycle; we1=1, waddr1=9, we2=0; ptr becomes 2.
- Fairness (RF_WB_ROTATE_EN): all four requesters continuously valid with distinct addrs → each granted exactly once per 2 cycles over 100 cycles.
- Fixed priority (macro undefined): same stimulus → only req 0 and req 1 are ever granted.
